// File: rtl/lexicon_gpio_ext_pkg.sv
// Shared register map, IRQ type encoding and decode helper for the GPIO extender.
package lexicon_gpio_ext_pkg;

    localparam int unsigned ADDR_W    = 6;
    localparam int unsigned DEB_DIV_W = 8;
    localparam int unsigned DEB_CNT_W = 3;

    localparam logic [ADDR_W-1:0] OFF_DIR        = 6'h00;
    localparam logic [ADDR_W-1:0] OFF_OUT        = 6'h04;
    localparam logic [ADDR_W-1:0] OFF_IN         = 6'h08;
    localparam logic [ADDR_W-1:0] OFF_OUT_SET    = 6'h0C;
    localparam logic [ADDR_W-1:0] OFF_OUT_CLR    = 6'h10;
    localparam logic [ADDR_W-1:0] OFF_IRQ_EN     = 6'h14;
    localparam logic [ADDR_W-1:0] OFF_IRQ_TYPE   = 6'h18;
    localparam logic [ADDR_W-1:0] OFF_IRQ_POL    = 6'h1C;
    localparam logic [ADDR_W-1:0] OFF_IRQ_BOTH   = 6'h20;
    localparam logic [ADDR_W-1:0] OFF_IRQ_STATUS = 6'h24;
    localparam logic [ADDR_W-1:0] OFF_DEB_EN     = 6'h28;
    localparam logic [ADDR_W-1:0] OFF_DEB_DIV    = 6'h2C;

    typedef enum logic {
        IRQ_LEVEL = 1'b0,
        IRQ_EDGE  = 1'b1
    } irq_type_e;

    // True for a word-aligned offset inside the implemented register window.
    function automatic logic offset_mapped(input logic [ADDR_W-1:0] addr);
        return (addr[1:0] == 2'b00) && (addr <= OFF_DEB_DIV);
    endfunction

endpackage

// File: rtl/lexicon_gpio_ext_filter.sv
// Per-pin input conditioning: synchroniser chain followed by an optional
// tick-based debouncer that owns the pin's IN bit.
// Ports: clk_i/rst_ni (sync active-low), pad_i async pad, tick_i shared
// debounce tick, deb_en_i debounce enable, in_o conditioned level.
module lexicon_gpio_ext_filter
    import lexicon_gpio_ext_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_CNT     = 3
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pad_i,
    input  logic tick_i,
    input  logic deb_en_i,
    output logic in_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DEB_CNT_W-1:0]   cnt_q, cnt_d;
    logic                   in_q, in_d;
    logic                   synced;

    // Count consecutive ticks that see a level differing from IN; without
    // debounce the synchronised level is copied straight through.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pad_i};
        synced = sync_q[SYNC_STAGES-1];
        cnt_d  = cnt_q;
        in_d   = in_q;
        if (!deb_en_i) begin
            in_d  = synced;
            cnt_d = '0;
        end else if (tick_i) begin
            if (synced == in_q) begin
                cnt_d = '0;
            end else if (cnt_q == DEB_CNT_W'(DEB_CNT - 1)) begin
                in_d  = synced;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '0;
            cnt_q  <= '0;
            in_q   <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            in_q   <= in_d;
        end
    end

    assign in_o = in_q;

endmodule

// File: rtl/lexicon_gpio_ext.sv
// APB4 GPIO extender: direction/output registers, conditioned inputs and
// per-pin level/edge interrupts with W1C status.
// Ports: pclk/prstn (sync active-low), APB4 slave (psel..pslverr, zero wait
// states), gpio_i async pads, gpio_o/gpio_oe pad drive, irq_o OR of status.
module lexicon_gpio_ext
    import lexicon_gpio_ext_pkg::*;
#(
    parameter int unsigned GPIO_PINS   = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_CNT     = 3
) (
    input  logic                   pclk,
    input  logic                   prstn,
    input  logic                   psel,
    input  logic                   penable,
    input  logic                   pwrite,
    input  logic [ADDR_W-1:0]      paddr,
    input  logic [GPIO_PINS/8-1:0] pstrb,
    input  logic [GPIO_PINS-1:0]   pwrdata,
    output logic [GPIO_PINS-1:0]   prddata,
    output logic                   pready,
    output logic                   pslverr,
    input  logic [GPIO_PINS-1:0]   gpio_i,
    output logic [GPIO_PINS-1:0]   gpio_o,
    output logic [GPIO_PINS-1:0]   gpio_oe,
    output logic                   irq_o
);

    logic [GPIO_PINS-1:0] dir_q, dir_d, out_q, out_d;
    logic [GPIO_PINS-1:0] en_q, en_d, type_q, type_d, pol_q, pol_d, both_q, both_d;
    logic [GPIO_PINS-1:0] status_q, status_d, deb_en_q, deb_en_d, in_prev_q;
    logic [DEB_DIV_W-1:0] deb_div_q, deb_div_d, presc_q, presc_d;

    logic [GPIO_PINS-1:0] in_w, strb_mask, wmask, w1c, irq_set;
    logic [GPIO_PINS-1:0] rise, fall, edge_evt, lvl, rdata;
    logic                 access, bad, wr_en, rd_en, tick;

    for (genvar g = 0; g < GPIO_PINS; g++) begin : g_mask
        assign strb_mask[g] = pstrb[g/8];
    end

    for (genvar g = 0; g < GPIO_PINS; g++) begin : g_pin
        lexicon_gpio_ext_filter #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEB_CNT     (DEB_CNT)
        ) u_filter (
            .clk_i    (pclk),
            .rst_ni   (prstn),
            .pad_i    (gpio_i[g]),
            .tick_i   (tick),
            .deb_en_i (deb_en_q[g]),
            .in_o     (in_w[g])
        );
    end

    // Access decode: illegal accesses raise pslverr and are otherwise ignored.
    always_comb begin
        access = psel & penable;
        bad    = !offset_mapped(paddr)
               || (pwrite && (paddr == OFF_IN))
               || (!pwrite && ((paddr == OFF_OUT_SET) || (paddr == OFF_OUT_CLR)));
        wr_en  = access & pwrite & ~bad;
        rd_en  = access & ~pwrite & ~bad;
    end

    // Read mux, driven only during a legal read access phase.
    always_comb begin
        rdata = '0;
        if (rd_en) begin
            case (paddr)
                OFF_DIR:        rdata = dir_q;
                OFF_OUT:        rdata = out_q;
                OFF_IN:         rdata = in_w;
                OFF_IRQ_EN:     rdata = en_q;
                OFF_IRQ_TYPE:   rdata = type_q;
                OFF_IRQ_POL:    rdata = pol_q;
                OFF_IRQ_BOTH:   rdata = both_q;
                OFF_IRQ_STATUS: rdata = status_q;
                OFF_DEB_EN:     rdata = deb_en_q;
                OFF_DEB_DIV:    rdata = GPIO_PINS'(deb_div_q);
                default:        rdata = '0;
            endcase
        end
    end

    // Reset forces the bus response quiet even while a transfer is presented.
    assign prddata = rdata & {GPIO_PINS{prstn}};
    assign pslverr = access & bad & prstn;
    assign pready  = 1'b1;

    // Register writes, prescaler and interrupt status next-state.
    always_comb begin
        dir_d     = dir_q;
        out_d     = out_q;
        en_d      = en_q;
        type_d    = type_q;
        pol_d     = pol_q;
        both_d    = both_q;
        deb_en_d  = deb_en_q;
        deb_div_d = deb_div_q;
        wmask     = pwrdata & strb_mask;
        w1c       = '0;

        tick    = (presc_q == deb_div_q);
        presc_d = tick ? '0 : presc_q + 1'b1;

        if (wr_en) begin
            case (paddr)
                OFF_DIR:        dir_d    = (dir_q & ~strb_mask) | wmask;
                OFF_OUT:        out_d    = (out_q & ~strb_mask) | wmask;
                OFF_OUT_SET:    out_d    = out_q | wmask;
                OFF_OUT_CLR:    out_d    = out_q & ~wmask;
                OFF_IRQ_EN:     en_d     = (en_q & ~strb_mask) | wmask;
                OFF_IRQ_TYPE:   type_d   = (type_q & ~strb_mask) | wmask;
                OFF_IRQ_POL:    pol_d    = (pol_q & ~strb_mask) | wmask;
                OFF_IRQ_BOTH:   both_d   = (both_q & ~strb_mask) | wmask;
                OFF_IRQ_STATUS: w1c      = wmask;
                OFF_DEB_EN:     deb_en_d = (deb_en_q & ~strb_mask) | wmask;
                OFF_DEB_DIV: begin
                    if (pstrb[0]) begin
                        deb_div_d = pwrdata[DEB_DIV_W-1:0];
                        presc_d   = '0;
                    end
                end
                default: ;
            endcase
        end

        // BOTH overrides POL for edges; level condition is IN == POL.
        rise     = in_w & ~in_prev_q;
        fall     = ~in_w & in_prev_q;
        edge_evt = (both_q & (rise | fall))
                 | (~both_q & ((pol_q & rise) | (~pol_q & fall)));
        lvl      = ~(in_w ^ pol_q);
        irq_set  = en_q & ((type_q & edge_evt) | (~type_q & lvl));

        // A set in the same cycle as W1C wins.
        status_d = (status_q & ~w1c) | irq_set;
    end

    always_ff @(posedge pclk) begin
        if (!prstn) begin
            dir_q     <= '0;
            out_q     <= '0;
            en_q      <= '0;
            type_q    <= '0;
            pol_q     <= '0;
            both_q    <= '0;
            status_q  <= '0;
            deb_en_q  <= '0;
            deb_div_q <= '0;
            presc_q   <= '0;
            in_prev_q <= '0;
        end else begin
            dir_q     <= dir_d;
            out_q     <= out_d;
            en_q      <= en_d;
            type_q    <= type_d;
            pol_q     <= pol_d;
            both_q    <= both_d;
            status_q  <= status_d;
            deb_en_q  <= deb_en_d;
            deb_div_q <= deb_div_d;
            presc_q   <= presc_d;
            in_prev_q <= in_w;
        end
    end

    assign gpio_o  = out_q;
    assign gpio_oe = dir_q;
    assign irq_o   = |status_q;

endmodule

// File: tb/tb_lexicon_gpio_ext.sv
// Scoreboard bench for lexicon_gpio_ext: the driver pushes expected bus and
// pin responses, a negedge monitor pops and compares them.
module tb_lexicon_gpio_ext;

    localparam int unsigned W    = 32;
    localparam int unsigned SYNC = 2;
    localparam int unsigned DCNT = 3;

    logic          pclk = 1'b0;
    logic          prstn;
    logic          psel, penable, pwrite;
    logic [5:0]    paddr;
    logic [3:0]    pstrb;
    logic [W-1:0]  pwrdata, prddata;
    logic          pready, pslverr;
    logic [W-1:0]  gpio_i, gpio_o, gpio_oe;
    logic          irq_o;
    logic          pin_chk = 1'b0;

    always #5 pclk = ~pclk;

    lexicon_gpio_ext #(
        .GPIO_PINS   (W),
        .SYNC_STAGES (SYNC),
        .DEB_CNT     (DCNT)
    ) dut (
        .pclk    (pclk),
        .prstn   (prstn),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pstrb   (pstrb),
        .pwrdata (pwrdata),
        .prddata (prddata),
        .pready  (pready),
        .pslverr (pslverr),
        .gpio_i  (gpio_i),
        .gpio_o  (gpio_o),
        .gpio_oe (gpio_oe),
        .irq_o   (irq_o)
    );

    typedef struct {
        bit          is_pin;
        bit          chk_data;
        logic [31:0] data;
        logic        err;
        logic [31:0] go;
        logic [31:0] goe;
        logic        irq;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_reg [0:11];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor: bus responses in the access phase, pin state on request.
    always @(negedge pclk) begin
        exp_t e;
        if (psel && penable) begin
            if (sb.size() == 0 || sb[0].is_pin) begin
                n_tests++; n_fail++;
                $display("FAIL apb_unexpected: got access at %h expected none", paddr);
            end else begin
                e = sb.pop_front();
                check({e.name, "_pready"}, 32'(pready), 32'd1);
                check({e.name, "_err"}, 32'(pslverr), 32'(e.err));
                if (e.chk_data) check({e.name, "_data"}, prddata, e.data);
            end
        end
        if (pin_chk) begin
            if (sb.size() == 0 || !sb[0].is_pin) begin
                n_tests++; n_fail++;
                $display("FAIL pin_unexpected: got pin sample expected none");
            end else begin
                e = sb.pop_front();
                check({e.name, "_gpio_o"}, gpio_o, e.go);
                check({e.name, "_gpio_oe"}, gpio_oe, e.goe);
                check({e.name, "_irq"}, 32'(irq_o), 32'(e.irq));
            end
        end
    end

    // Reference rules for access legality.
    function automatic bit m_err(input bit w, input logic [5:0] a);
        return (a[1:0] != 2'b00) || (a > 6'h2C) || (w && a == 6'h08)
            || (!w && (a == 6'h0C || a == 6'h10));
    endfunction

    function automatic void m_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] m;
        int idx;
        for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{s[i]}};
        idx = int'(a[5:2]);
        case (a)
            6'h0C: m_reg[1] = m_reg[1] | (d & m);
            6'h10: m_reg[1] = m_reg[1] & ~(d & m);
            6'h24: m_reg[9] = m_reg[9] & ~(d & m);
            6'h2C: if (s[0]) m_reg[11] = {24'h0, d[7:0]};
            default: m_reg[idx] = (m_reg[idx] & ~m) | (d & m);
        endcase
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic apb(input bit w, input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwrdata = d; pstrb = s;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    function automatic void push_apb(input string name, input bit chk, input logic [31:0] d, input logic err);
        exp_t e;
        e.is_pin = 1'b0; e.chk_data = chk; e.data = d; e.err = err;
        e.go = '0; e.goe = '0; e.irq = 1'b0; e.name = name;
        sb.push_back(e);
    endfunction

    task automatic wr(input string name, input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
        bit err;
        err = m_err(1'b1, a);
        push_apb(name, err, 32'h0, err);
        apb(1'b1, a, d, s);
        if (!err) m_write(a, d, s);
    endtask

    task automatic rd_model(input string name, input logic [5:0] a);
        bit err;
        err = m_err(1'b0, a);
        push_apb(name, 1'b1, err ? 32'h0 : m_reg[a[5:2]], err);
        apb(1'b0, a, 32'h0, 4'h0);
    endtask

    task automatic rd_exp(input string name, input logic [5:0] a, input logic [31:0] exp);
        push_apb(name, 1'b1, exp, 1'b0);
        apb(1'b0, a, 32'h0, 4'h0);
    endtask

    task automatic pin_check(input string name, input logic [31:0] go, input logic [31:0] goe, input logic irq);
        exp_t e;
        e.is_pin = 1'b1; e.chk_data = 1'b0; e.data = '0; e.err = 1'b0;
        e.go = go; e.goe = goe; e.irq = irq; e.name = name;
        sb.push_back(e);
        pin_chk = 1'b1;
        @(posedge pclk); #1;
        pin_chk = 1'b0;
    endtask

    task automatic pin_irq(input string name, input logic irq);
        pin_check(name, m_reg[1], m_reg[0], irq);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    logic [5:0] rw_addr [0:7];
    logic [5:0] a;
    bit         w;

    initial begin
        rw_addr = '{6'h00, 6'h04, 6'h18, 6'h1C, 6'h20, 6'h24, 6'h28, 6'h2C};
        for (int i = 0; i < 12; i++) m_reg[i] = '0;
        prstn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pstrb = '0; pwrdata = '0; gpio_i = '0;
        cycles(3);
        pin_check("reset", 32'h0, 32'h0, 1'b0);
        prstn = 1'b1;
        cycles(1);

        // Output path and strobes.
        wr("dir", 6'h00, 32'h0000_00FF, 4'hF);
        wr("set", 6'h0C, 32'h0000_0005, 4'h1);
        pin_check("r25_set", 32'h0000_0005, 32'h0000_00FF, 1'b0);
        wr("set_lane_off", 6'h0C, 32'h0000_0500, 4'h1);
        pin_irq("r25_lane_off", 1'b0);
        wr("clr", 6'h10, 32'h0000_0001, 4'hF);
        pin_check("r25_clr", 32'h0000_0004, 32'h0000_00FF, 1'b0);

        // Illegal accesses.
        rd_model("rd_0x30", 6'h30);
        wr("wr_in", 6'h08, 32'hFFFF_FFFF, 4'hF);
        rd_model("rd_out_set", 6'h0C);
        wr("wr_unaligned", 6'h01, 32'hFFFF_FFFF, 4'hF);
        wr("wr_0x3c", 6'h3C, 32'hFFFF_FFFF, 4'hF);
        rd_model("rd_dir_after_err", 6'h00);
        rd_model("rd_out_after_err", 6'h04);

        // Randomised register traffic with pins idle and IRQ_EN kept at 0.
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 4))
                0: wr("rnd_wr", rw_addr[$urandom_range(0, 7)], $urandom, 4'($urandom_range(0, 15)));
                1: wr("rnd_setclr", ($urandom_range(0, 1) != 0) ? 6'h0C : 6'h10, $urandom, 4'($urandom_range(0, 15)));
                2: rd_model("rnd_rd", 6'($urandom_range(0, 15) << 2));
                3: begin
                    a = 6'($urandom_range(0, 63));
                    w = ($urandom_range(0, 1) != 0);
                    if (!m_err(w, a)) a = a | 6'h01;
                    if (w) wr("rnd_err_wr", a, $urandom, 4'hF);
                    else   rd_model("rnd_err_rd", a);
                end
                default: pin_irq("rnd_pins", 1'b0);
            endcase
        end
        for (int i = 0; i < 12; i++) rd_model("rnd_readback", 6'(i << 2));

        wr("clean_deben", 6'h28, 32'h0, 4'hF);
        wr("clean_div", 6'h2C, 32'h0, 4'hF);
        wr("clean_type", 6'h18, 32'h0, 4'hF);
        wr("clean_pol", 6'h1C, 32'h0, 4'hF);
        wr("clean_both", 6'h20, 32'h0, 4'hF);

        // Both-edge interrupt on pin 3.
        wr("r27_type", 6'h18, 32'h8, 4'hF);
        wr("r27_both", 6'h20, 32'h8, 4'hF);
        wr("r27_en", 6'h14, 32'h8, 4'hF);
        pin_irq("r27_idle", 1'b0);
        gpio_i[3] = 1'b1;
        cycles(SYNC + 1);
        pin_irq("r27_rise_early", 1'b0);
        pin_irq("r27_rise", 1'b1);
        rd_exp("r27_status", 6'h24, 32'h8);
        wr("r27_w1c", 6'h24, 32'h8, 4'hF);
        pin_irq("r27_w1c_irq", 1'b0);
        gpio_i[3] = 1'b0;
        cycles(SYNC + 1);
        pin_irq("r27_fall_early", 1'b0);
        pin_irq("r27_fall", 1'b1);
        wr("r27_w1c2", 6'h24, 32'h8, 4'hF);
        pin_irq("r27_w1c2_irq", 1'b0);

        // Level re-set after W1C, set-over-clear priority, EN clear keeps status.
        wr("r28_pol", 6'h1C, 32'h1, 4'hF);
        gpio_i[0] = 1'b1;
        cycles(5);
        wr("r28_en", 6'h14, 32'h9, 4'hF);
        rd_exp("r28_status", 6'h24, 32'h1);
        wr("r28_w1c", 6'h24, 32'h1, 4'hF);
        rd_exp("r28_relevel", 6'h24, 32'h1);
        gpio_i[3] = 1'b1;
        cycles(5);
        rd_exp("r28_edge", 6'h24, 32'h9);
        gpio_i[3] = 1'b0;
        cycles(1);
        wr("r28_w1c_coincide", 6'h24, 32'h8, 4'hF);
        rd_exp("r28_coincide", 6'h24, 32'h9);
        wr("r28_w1c_plain", 6'h24, 32'h8, 4'hF);
        rd_exp("r28_cleared", 6'h24, 32'h1);
        wr("r18_en_off", 6'h14, 32'h0, 4'hF);
        rd_exp("r18_status_kept", 6'h24, 32'h1);
        pin_irq("r18_irq_kept", 1'b1);
        wr("r18_w1c_all", 6'h24, 32'hFFFF_FFFF, 4'hF);
        rd_exp("r18_status_clr", 6'h24, 32'h0);
        pin_irq("r18_irq_clr", 1'b0);

        // Debounce on pin 1 with a 5-cycle tick.
        wr("r29_div", 6'h2C, 32'h4, 4'hF);
        wr("r29_deben", 6'h28, 32'h2, 4'hF);
        gpio_i[1] = 1'b1;
        cycles(10);
        gpio_i[1] = 1'b0;
        cycles(20);
        rd_exp("r29_glitch", 6'h08, 32'h1);
        wr("r29_div_restart", 6'h2C, 32'h4, 4'hF);
        gpio_i[1] = 1'b1;
        cycles(11);
        rd_exp("r29_before_3rd_tick", 6'h08, 32'h1);
        rd_exp("r29_after_3rd_tick", 6'h08, 32'h3);
        gpio_i[1] = 1'b0;
        cycles(3);
        rd_exp("r29_hold", 6'h08, 32'h3);
        wr("r29_deben_off", 6'h28, 32'h0, 4'hF);
        rd_exp("r29_passthrough", 6'h08, 32'h1);

        // Reset mid-debounce with pending status.
        wr("r30_dir", 6'h00, 32'h0000_F0F0, 4'hF);
        wr("r30_out", 6'h04, 32'h0000_1234, 4'hF);
        wr("r30_en", 6'h14, 32'h1, 4'hF);
        wr("r30_deben", 6'h28, 32'h2, 4'hF);
        gpio_i[1] = 1'b1;
        cycles(3);
        pin_irq("r30_pre", 1'b1);
        prstn = 1'b0;
        cycles(1);
        pin_check("r30_in_reset", 32'h0, 32'h0, 1'b0);
        push_apb("r30_bus_in_reset", 1'b1, 32'h0, 1'b0);
        apb(1'b0, 6'h30, 32'h0, 4'h0);
        prstn = 1'b1;
        for (int i = 0; i < 12; i++) m_reg[i] = '0;
        cycles(10);
        pin_irq("r30_post", 1'b0);
        rd_exp("r30_status", 6'h24, 32'h0);
        rd_exp("r30_in", 6'h08, 32'h3);
        rd_model("r30_dir_rd", 6'h00);

        cycles(2);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lexicon_gpio_ext.md
LEXICON_GPIO_EXT -- requirements
Module: lexicon_gpio_ext

Interface
REQ-001 SHALL have parameter GPIO_PINS, default 32, pin count and APB data width; legal values 8, 16, 24, 32.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, input synchroniser depth; legal values 2..3.
REQ-003 SHALL have parameter DEB_CNT, default 3, consecutive equal debounce samples needed to accept a new level; legal values 2..7.
REQ-004 SHALL have ports: pclk  in  1  clock; prstn  in  1  reset, one clock, synchronous, active-low.
REQ-005 SHALL have ports: psel in 1; penable in 1; pwrite in 1; paddr in 6 (byte address); pstrb in GPIO_PINS/8; pwrdata in GPIO_PINS; prddata out GPIO_PINS; pready out 1; pslverr out 1; all APB4 semantics.
REQ-006 SHALL have ports: gpio_i in GPIO_PINS (asynchronous pads); gpio_o out GPIO_PINS; gpio_oe out GPIO_PINS (1 = drive); irq_o out 1 (active-high).

Function
REQ-007 SHALL decode word registers: 0x00 DIR rw; 0x04 OUT rw; 0x08 IN ro; 0x0C OUT_SET wo; 0x10 OUT_CLR wo; 0x14 IRQ_EN rw; 0x18 IRQ_TYPE rw (0 level, 1 edge); 0x1C IRQ_POL rw (1 high/rising, 0 low/falling); 0x20 IRQ_BOTH rw (edge on both transitions, overrides POL); 0x24 IRQ_STATUS rw1c; 0x28 DEB_EN rw; 0x2C DEB_DIV rw, bits [7:0] only.
REQ-008 SHALL keep pready = 1 at all times (zero wait states); register write occurs in the access phase (psel & penable & pwrite).
REQ-009 SHALL assert pslverr during the access phase for unmapped offsets, non-word-aligned paddr, writes to IN, and reads of OUT_SET/OUT_CLR; such accesses change no state, and prddata = 0.
REQ-010 SHALL apply writes per byte lane per pstrb; lanes with pstrb = 0 are unchanged, including for OUT_SET, OUT_CLR and IRQ_STATUS.
REQ-011 SHALL drive gpio_o = OUT and gpio_oe = DIR directly from registers; OUT_SET ORs and OUT_CLR clears masked bits in the cycle after the access.
REQ-012 SHALL pass each gpio_i bit through SYNC_STAGES flops; IN shows the synchronised value after SYNC_STAGES+1 cycles when DEB_EN bit = 0.
REQ-013 SHALL generate a shared debounce tick every DEB_DIV+1 cycles; DEB_DIV = 0 gives a tick every cycle; writing DEB_DIV restarts the prescaler at 0.
REQ-014 SHALL, for pins with DEB_EN = 1, update IN only after DEB_CNT consecutive ticks sample the same synchronised value differing from IN; any mismatch resets that pin's count to 0; clearing DEB_EN passes the synchronised value through on the next cycle.
REQ-015 SHALL detect edges on IN versus its previous-cycle value; level condition = (IN == POL).
REQ-016 SHALL set IRQ_STATUS bit when IRQ_EN = 1 and its event/condition is true; level-type bits re-set every cycle while condition persists, even after W1C.
REQ-017 SHALL give set priority over W1C clear when both occur in the same cycle on the same bit.
REQ-018 SHALL not clear IRQ_STATUS when IRQ_EN is cleared; disabled bits only stop setting.
REQ-019 SHALL drive irq_o = OR of IRQ_STATUS (register-driven, no combinational path from gpio_i or APB).
REQ-020 SHALL return all rw register contents on read in the same access phase; unimplemented DEB_DIV bits read 0.

Reset
REQ-021 SHALL on prstn = 0 at a pclk edge clear DIR, OUT, IRQ_EN, IRQ_TYPE, IRQ_POL, IRQ_BOTH, IRQ_STATUS, DEB_EN, DEB_DIV, IN, synchroniser flops, debounce counters and prescaler; gpio_o = 0, gpio_oe = 0, irq_o = 0, pslverr = 0, prddata = 0.
REQ-022 SHALL abandon any in-progress access or debounce count on reset without generating an edge event on the first post-reset cycle.

Structure
REQ-023 SHALL place register offset constants and the IRQ type enum in package lexicon_gpio_ext_pkg.
REQ-024 SHALL implement the per-pin synchroniser plus debounce counter as sub-module lexicon_gpio_ext_filter, instantiated GPIO_PINS times, sharing the tick.

Verification
REQ-025 Write DIR = 0x0000_00FF, OUT_SET = 0x0000_0005 with pstrb = 4'b0001 -> gpio_oe = 0x0000_00FF, gpio_o = 0x0000_0005; OUT_CLR 0x1 -> gpio_o = 0x0000_0004.
REQ-026 Read 0x30, write IN -> pslverr = 1, prddata = 0, no register change.
REQ-027 IRQ_EN[3] = 1, TYPE[3] = 1, BOTH[3] = 1; toggle gpio_i[3] 0->1->0 -> STATUS[3] set after SYNC_STAGES+2 cycles each time, irq_o high; W1C 0x8 -> irq_o low.
REQ-028 Level-high on pin 0 held high, W1C STATUS[0] -> bit reads 1 again next cycle; W1C coinciding with a new edge -> bit stays set.
REQ-029 DEB_EN[1] = 1, DEB_DIV = 4, DEB_CNT = 3: 2-tick glitch on gpio_i[1] -> IN[1] unchanged; stable level -> IN[1] updates after 3 ticks (15 cycles nominal).
REQ-030 Assert prstn = 0 mid-debounce with STATUS nonzero -> all outputs 0 next edge; no IRQ after release with gpio_i static.
